dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the CPU MEM stage (cpu_*) and a DMA/debug loader port (dma_*).
- Grants at most one access per cycle and drives the memory's address, write-data and read/write strobes from the winner.
- Reads are combinational at the memory. The arbiter registers read data and returns it one cycle after grant.
- Arbitration is round-robin with a burst allowance, so neither port starves.

---
 rtl/dmem_arb_pkg.sv | 6 +
 rtl/dmem_rr_pick.sv | 42 ++++
 rtl/dmem_arbiter.sv | 83 ++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding and default bus widths for the data-memory arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational round-robin winner selection with a burst allowance,
// plus the owner / beat-count registers that remember who won last and how often.
module dmem_rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_win,
    output logic dma_win
);
    localparam logic [CNT_W-1:0] BURST = CNT_W'(MAX_BURST);

    owner_t           owner, owner_next;
    logic [CNT_W-1:0] beat_cnt, beat_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= OWN_CPU;
            beat_cnt <= '0;
        end else begin
            owner    <= owner_next;
            beat_cnt <= beat_next;
        end
    end

    // The owner keeps the bus under contention until it has used its burst allowance.
    always_comb begin
        dma_win    = (cpu_req && dma_req) ? ((beat_cnt < BURST) ? (owner == OWN_DMA) : (owner == OWN_CPU)) : dma_req;
        cpu_win    = cpu_req && !dma_win;
        owner_next = owner;
        beat_next  = '0;
        if (cpu_win || dma_win) begin
            owner_next = dma_win ? OWN_DMA : OWN_CPU;
            beat_next  = (owner_next != owner) ? CNT_W'(1) : (beat_cnt == BURST) ? BURST : beat_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage and a DMA port.
// Defining DMEM_ARB_STATS_EN adds per-port saturating stall counters cleared by stats_clr.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,input  logic              stats_clr,
    output logic [15:0]       cpu_stall_cnt,
    output logic [15:0]       dma_stall_cnt
`endif
);
    dmem_rr_pick #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_pick (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .cpu_win(cpu_gnt),
        .dma_win(dma_gnt)
    );

    always_comb begin
        mem_addr  = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
        mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
        mem_write = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
        mem_read  = (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
    end

    // Memory reads are combinational, so the granted read's data is captured at the grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
            if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_stall_cnt <= '0;
            dma_stall_cnt <= '0;
        end else if (stats_clr) begin
            cpu_stall_cnt <= '0;
            dma_stall_cnt <= '0;
        end else begin
            if (cpu_req && !cpu_gnt && cpu_stall_cnt != 16'hFFFF) cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            if (dma_req && !dma_gnt && dma_stall_cnt != 16'hFFFF) dma_stall_cnt <= dma_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed scoreboard bench for dmem_arbiter with a
// behavioural memory and arbitration model.
module tb_dmem_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0, reset = 1'b1, init_phase = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_read, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] cpu_stall_cnt, dma_stall_cnt;
    int          c_stall = 0, d_stall = 0;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
       ,.stats_clr(stats_clr), .cpu_stall_cnt(cpu_stall_cnt), .dma_stall_cnt(dma_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, write at the clock edge.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (init_phase) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {int cyc; logic [31:0] data;} exp_t;
    exp_t        cq[$], dq[$];
    logic [31:0] c_last = '0, d_last = '0;
    int          owner = 0, streak = 0;
    bit          c_g = 0, d_g = 0;

    // Reference model: who should win this cycle, what the memory sees, and what reads return.
    task automatic check();
        int          w;
        logic [31:0] ea, ed;
        logic        ew;
        exp_t        e;
        if (c_req && d_req) w = (streak < MAXB) ? owner + 1 : 2 - owner;
        else w = c_req ? 1 : d_req ? 2 : 0;
        ea = (w == 1) ? c_addr : (w == 2) ? d_addr : 32'h0;
        ed = (w == 1) ? c_wdata : (w == 2) ? d_wdata : 32'h0;
        ew = (w == 1) ? c_we : (w == 2) ? d_we : 1'b0;
        chk("cpu_gnt", 32'(cpu_gnt), 32'(w == 1));
        chk("dma_gnt", 32'(dma_gnt), 32'(w == 2));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_read", 32'(mem_read), 32'(w != 0 && !ew));
        chk("mem_write", 32'(mem_write), 32'(w != 0 && ew));
`ifdef DMEM_ARB_STATS_EN
        chk("cpu_stall_cnt", 32'(cpu_stall_cnt), 32'(c_stall));
        chk("dma_stall_cnt", 32'(dma_stall_cnt), 32'(d_stall));
        if (stats_clr) begin
            c_stall = 0;
            d_stall = 0;
        end else begin
            if (c_req && w != 1 && c_stall < 65535) c_stall++;
            if (d_req && w != 2 && d_stall < 65535) d_stall++;
        end
`endif
        if (w != 0) begin
            if (ew) ref_mem[ea[9:2]] = ed;
            else begin
                e.cyc = cyc;
                e.data = ref_mem[ea[9:2]];
                if (w == 1) cq.push_back(e);
                else dq.push_back(e);
            end
        end
        if (w == 0) streak = 0;
        else if (w - 1 == owner) streak = (streak < MAXB) ? streak + 1 : MAXB;
        else begin
            owner = w - 1;
            streak = 1;
        end
        c_g = (w == 1);
        d_g = (w == 2);
    endtask

    // Monitor: every rvalid must match the oldest outstanding read, exactly one cycle after grant.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_rvalid) begin
            if (cq.size() == 0) chk("cpu_rvalid_spurious", 32'(1), 32'(0));
            else begin
                e = cq.pop_front();
                chk("cpu_rvalid_latency", 32'(cyc - e.cyc), 32'(1));
                chk("cpu_rdata", cpu_rdata, e.data);
                c_last = e.data;
            end
        end else begin
            chk("cpu_rdata_hold", cpu_rdata, c_last);
            if (cq.size() > 0 && cq[0].cyc < cyc) begin
                chk("cpu_rvalid_missing", 32'(0), 32'(1));
                void'(cq.pop_front());
            end
        end
        if (dma_rvalid) begin
            if (dq.size() == 0) chk("dma_rvalid_spurious", 32'(1), 32'(0));
            else begin
                e = dq.pop_front();
                chk("dma_rvalid_latency", 32'(cyc - e.cyc), 32'(1));
                chk("dma_rdata", dma_rdata, e.data);
                d_last = e.data;
            end
        end else begin
            chk("dma_rdata_hold", dma_rdata, d_last);
            if (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("dma_rvalid_missing", 32'(0), 32'(1));
                void'(dq.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic new_c();
        c_we = 1'($urandom_range(0, 1));
        c_addr = $urandom & 32'h3FF;
        c_wdata = $urandom;
    endtask

    task automatic new_d();
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom & 32'h3FF;
        d_wdata = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cq.delete();
        dq.delete();
        c_last = '0;
        d_last = '0;
        owner = 0;
        streak = 0;
        c_req = 1'b0;
        d_req = 1'b0;
        c_g = 0;
        d_g = 0;
`ifdef DMEM_ARB_STATS_EN
        c_stall = 0;
        d_stall = 0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic both_run(int n);
        c_req = 1'b1;
        d_req = 1'b1;
        new_c();
        new_d();
        for (int i = 0; i < n; i++) begin
            tick();
            if (c_g) new_c();
            if (d_g) new_d();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (2) @(posedge clk);
        #1 init_phase = 1'b0;
        reset = 1'b0;
        repeat (3) tick();

        // CPU write then read-after-write to the same address.
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h1234_5678;
        tick();
        c_we = 1'b0;
        tick();
        c_req = 1'b0;
        repeat (2) tick();
        chk("raw_cpu_rdata", cpu_rdata, 32'h1234_5678);

        // Continuous contention: CPU x4, DMA x4, CPU x4.
        both_run(12);
        c_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();

        // DMA-only read stream.
        d_req = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d_addr = 32'(i * 4);
            tick();
        end
        d_req = 1'b0;
        repeat (2) tick();
        chk("dma_stream_last", dma_rdata, init_val(5));

        // Reset lands while a granted CPU read is still in flight.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
        @(negedge clk);
        check();
        #1 do_reset();
        repeat (2) tick();
        chk("reset_drops_rdata", cpu_rdata, 32'h0);

        // Contention right after reset must again start with the CPU.
        both_run(10);
`ifdef DMEM_ARB_STATS_EN
        chk("stall_cpu_10", 32'(cpu_stall_cnt), 32'd4);
        chk("stall_dma_10", 32'(dma_stall_cnt), 32'd6);
        stats_clr = 1'b1;
`endif
        c_req = 1'b0; d_req = 1'b0;
        tick();
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 1'b0;
        chk("stall_cpu_clr", 32'(cpu_stall_cnt), 32'd0);
        chk("stall_dma_clr", 32'(dma_stall_cnt), 32'd0);
`endif
        tick();

        // Random traffic: a requester holds its request until granted.
        for (int i = 0; i < 400; i++) begin
            if (c_g || !c_req) begin
                c_req = ($urandom_range(0, 3) != 0);
                new_c();
            end
            if (d_g || !d_req) begin
                d_req = ($urandom_range(0, 3) != 0);
                new_d();
            end
`ifdef DMEM_ARB_STATS_EN
            stats_clr = (i == 200);
`endif
            tick();
        end
        c_req = 1'b0; d_req = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) tick();
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
        chk("dma_queue_drained", 32'(dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
